hs_fifo: RTL and testbench



---
 rtl/hs_fifo_pkg.sv | 20 ++
 rtl/hs_fifo_dff.sv | 35 +++
 rtl/hs_fifo.sv | 88 ++++++++
 tb/tb_hs_fifo.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/hs_fifo_pkg.sv
// Shared helpers for the hs_fifo flop library: pointer-width derivation and
// the depth legality check evaluated at elaboration time.
package hs_fifo_pkg;

  // Smallest r with 2**r >= v (v >= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  // Depth must be a power of two and at least 2 so the wrap bit works.
  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/hs_fifo_dff.sv
// Flop primitives: dffl (load-enable, no reset) for data storage and
// dfflr (load-enable, async active-low reset to zero) for control state.
module dffl #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  // Capture dnxt only when enabled; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (lden) qout <= dnxt;
  end

endmodule

module dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  // Async clear to zero, otherwise capture dnxt when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    qout <= '0;
    else if (lden) qout <= dnxt;
  end

endmodule

// File: rtl/hs_fifo.sv
// hs_fifo: single-clock valid/ready FIFO. Outputs depend only on registered
// pointers and entries, so there is no combinational path from i_vld/o_rdy
// to any output.
// Handshake: a transfer happens on a rising edge where both vld and rdy are
// high on that side; vld never depends on rdy of the same side.
module hs_fifo
  import hs_fifo_pkg::*;
#(
  parameter  int DW = 32,
  parameter  int DP = 4,
  localparam int AW = clog2(DP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [AW:0]   cnt
);

  if (!is_pow2(DP)) begin : g_bad_dp
    $error("hs_fifo: DP must be a power of two and >= 2");
  end

  logic [AW:0]   wptr, rptr, cnt_q;
  logic [AW:0]   wptr_nxt, rptr_nxt, cnt_nxt;
  logic          empty, full, push, pop;
  logic [DW-1:0] ent [DP];
  logic [DW-1:0] rd_dat;

  // Same index with differing wrap bits means every slot is occupied.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  assign i_rdy = ~full;
  assign o_vld = ~empty;
  assign push  = i_vld & i_rdy;
  assign pop   = o_vld & o_rdy;

  assign wptr_nxt = wptr + (AW+1)'(1);
  assign rptr_nxt = rptr + (AW+1)'(1);

  // Occupancy moves only when exactly one side transfers.
  always_comb begin
    cnt_nxt = cnt_q;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt_q + (AW+1)'(1);
      2'b01:   cnt_nxt = cnt_q - (AW+1)'(1);
      default: cnt_nxt = cnt_q;
    endcase
  end

  dfflr #(.DW(AW+1)) u_wptr (
    .clk(clk), .rst_n(rst_n), .lden(push), .dnxt(wptr_nxt), .qout(wptr)
  );

  dfflr #(.DW(AW+1)) u_rptr (
    .clk(clk), .rst_n(rst_n), .lden(pop), .dnxt(rptr_nxt), .qout(rptr)
  );

  dfflr #(.DW(AW+1)) u_cnt (
    .clk(clk), .rst_n(rst_n), .lden(push ^ pop), .dnxt(cnt_nxt), .qout(cnt_q)
  );

  for (genvar g = 0; g < DP; g++) begin : g_ent
    dffl #(.DW(DW)) u_ent (
      .clk (clk),
      .lden(push && (wptr[AW-1:0] == AW'(g))),
      .dnxt(i_dat),
      .qout(ent[g])
    );
  end

  // Flat AND-OR read mux selecting the head entry.
  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < DP; i++) begin
      rd_dat = rd_dat | ({DW{rptr[AW-1:0] == AW'(i)}} & ent[i]);
    end
  end

  assign o_dat = rd_dat;
  assign cnt   = cnt_q;

endmodule

// File: tb/tb_hs_fifo.sv
// Bench for hs_fifo (DW=8, DP=4): directed scenarios followed by random
// valid/ready traffic, checked against a queue-based reference model.
module tb_hs_fifo;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic [AW:0]   cnt;

  int vectors;
  int miscompares;

  logic [DW-1:0] exp_q[$];
  int            ref_cnt;

  hs_fifo #(.DW(DW), .DP(DP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .i_vld(i_vld),
    .i_rdy(i_rdy),
    .i_dat(i_dat),
    .o_vld(o_vld),
    .o_rdy(o_rdy),
    .o_dat(o_dat),
    .cnt  (cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract FIFO: a word is accepted whenever fewer than DP words are held,
  // removed whenever at least one is held and the consumer is ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      ref_cnt <= 0;
    end else begin
      if (i_vld && (ref_cnt < DP)) exp_q.push_back(i_dat);
      ref_cnt <= ref_cnt + ((i_vld && (ref_cnt < DP)) ? 1 : 0)
                         - ((o_rdy && (ref_cnt > 0)) ? 1 : 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    chk("cnt", int'(cnt), ref_cnt);
    chk("o_vld", int'(o_vld), (ref_cnt != 0) ? 1 : 0);
    chk("i_rdy", int'(i_rdy), (ref_cnt < DP) ? 1 : 0);
    if (cnt > DP) chk("cnt_bound", int'(cnt), DP);
    if (ref_cnt != 0) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_empty", 0, 1);
      end else begin
        chk("o_dat", int'(o_dat), int'(exp_q[0]));
        if (o_rdy) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; applies inputs for one cycle and returns at the
  // next posedge+1.
  task automatic cyc(input logic vld, input logic [DW-1:0] dat, input logic rdy);
    i_vld = vld;
    i_dat = dat;
    o_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, DW'($urandom), 1'b0);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, DW'($urandom), 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] fill_tab [4];
    fill_tab[0] = 8'h11; fill_tab[1] = 8'h22;
    fill_tab[2] = 8'h33; fill_tab[3] = 8'h44;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    i_vld = 1'b0;
    i_dat = '0;
    o_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: idle after reset
    idle(10);

    // 2: fill without pop, refused fifth push, drain in order
    for (int k = 0; k < 4; k++) cyc(1'b1, fill_tab[k], 1'b0);
    chk("full_i_rdy", int'(i_rdy), 0);
    chk("full_cnt", int'(cnt), 4);
    cyc(1'b1, 8'h55, 1'b0);
    drain(5);
    chk("drained_o_vld", int'(o_vld), 0);

    // 3: streaming 16 words through, pointers wrap several times
    for (int k = 0; k < 16; k++) cyc(1'b1, DW'(k), 1'b1);
    drain(1);

    // 4: full with simultaneous push and pop
    for (int k = 0; k < 4; k++) cyc(1'b1, DW'(8'hC0 + k), 1'b0);
    cyc(1'b1, 8'hEE, 1'b1);
    chk("full_pop_cnt", int'(cnt), 3);
    chk("full_pop_i_rdy", int'(i_rdy), 1);
    cyc(1'b1, 8'hEF, 1'b0);
    drain(5);

    // 5: empty with consumer ready and one push
    cyc(1'b1, 8'hA5, 1'b1);
    chk("empty_push_cnt", int'(cnt), 1);
    chk("empty_push_dat", int'(o_dat), 8'hA5);
    drain(2);

    // 6: asynchronous reset at occupancy 3
    for (int k = 0; k < 3; k++) cyc(1'b1, DW'(8'h60 + k), 1'b0);
    i_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", int'(cnt), 0);
    chk("arst_o_vld", int'(o_vld), 0);
    chk("arst_i_rdy", int'(i_rdy), 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 8'h7E, 1'b0);
    chk("post_rst_dat", int'(o_dat), 8'h7E);
    drain(2);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    end
    drain(6);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
